gate_vector_sequencer: RTL and testbench

Self-checking stimulus/response stage for the two-input basic-gate block: drives its `A`/`B` inputs through all four input combinations, holds each one for a programmable settle time, then samples the seven gate outputs and compares them against a golden model. It replaces hand-written per-vector delays with a synthesizable, clocked sequencer. It reports a one-cycle completion pulse, a pass flag, a sticky per-gate error mask and a mismatch count.

---
 rtl/gate_vec_pkg.sv | 27 ++
 rtl/gate_ref_model.sv | 23 ++
 rtl/gate_vector_sequencer.sv | 148 ++++++++++++++
 tb/tb_gate_vector_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/gate_vec_pkg.sv
// Shared types and constants for the two-input gate vector sequencer.
// Bit positions of gate_y and the golden response per {a,b} vector.
package gate_vec_pkg;

  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int NY_BIT  = 0;
  localparam int AY_BIT  = 1;
  localparam int OY_BIT  = 2;
  localparam int NAY_BIT = 3;
  localparam int NOY_BIT = 4;
  localparam int XY_BIT  = 5;
  localparam int XNY_BIT = 6;

  localparam logic [6:0] EXP_00 = 7'h59;
  localparam logic [6:0] EXP_01 = 7'h2D;
  localparam logic [6:0] EXP_10 = 7'h2C;
  localparam logic [6:0] EXP_11 = 7'h46;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the basic-gate block: {a,b} in, expected
// seven gate outputs out (bit order fixed by the *_BIT constants).
module gate_ref_model
  import gate_vec_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] exp_y
);

  // Lookup of the expected gate response for the applied vector.
  always_comb begin
    exp_y = 7'h00;
    case ({a, b})
      2'b00:   exp_y = EXP_00;
      2'b01:   exp_y = EXP_01;
      2'b10:   exp_y = EXP_10;
      2'b11:   exp_y = EXP_11;
      default: exp_y = 7'h00;
    endcase
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Clocked stimulus/response sequencer: walks {a,b} through 00..11, holds each
// vector HOLD_CYCLES cycles, samples gate_y and accumulates mismatches.
module gate_vector_sequencer
  import gate_vec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask,
  output logic [2:0] err_count
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [6:0]        err_mask_q, err_mask_d;
  logic [2:0]        err_count_q, err_count_d;
  logic [6:0]        exp_y;
  logic [6:0]        diff;

  // Golden model sees the registered stimulus, which equals idx while sampling.
  gate_ref_model u_ref (
    .a     (a_q),
    .b     (b_q),
    .exp_y (exp_y)
  );

  assign diff = gate_y ^ exp_y;

  // Next-state, stimulus and accumulator logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d     = ST_APPLY;
          idx_d       = 2'd0;
          hold_d      = HOLD_LOAD;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_mask_d  = 7'h00;
          err_count_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_APPLY: begin
        if (hold_q == {HOLD_W{1'b0}}) begin
          state_d = ST_SAMPLE;
        end else begin
          hold_d = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SAMPLE: begin
        err_mask_d  = err_mask_q | diff;
        err_count_d = err_count_q + {2'b00, |diff};
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (err_count_d == 3'd0);
        end else begin
          // Next vector's stimulus is registered on entry to APPLY.
          state_d    = ST_APPLY;
          idx_d      = idx_q + 2'd1;
          hold_d     = HOLD_LOAD;
          {a_d, b_d} = idx_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      hold_q      <= {HOLD_W{1'b0}};
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_mask_q  <= 7'h00;
      err_count_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Randomized self-checking bench: a behavioural gate block with per-vector
// fault injection drives two sequencer instances (H=4 and H=1).
module tb_gate_vector_sequencer;

  localparam int H  = 4;
  localparam int H1 = 1;

  logic       clk = 1'b0;
  logic       rst, start, start1;
  logic       a, b, busy, done, pass;
  logic       a1, b1, busy1, done1, pass1;
  logic [6:0] gate_y, gate_y1, err_mask, err_mask1;
  logic [2:0] err_count, err_count1;
  logic [6:0] fault  [4];
  logic [6:0] fault1 [4];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  // Behavioural gate block: {xny, xy, noy, nay, oy, ay, ny}
  function automatic logic [6:0] gold(input logic ga, input logic gb);
    return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb, ~ga};
  endfunction

  assign gate_y  = gold(a, b)   ^ fault[{a, b}];
  assign gate_y1 = gold(a1, b1) ^ fault1[{a1, b1}];

  gate_vector_sequencer #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .gate_y(gate_y),
    .busy(busy), .done(done), .pass(pass), .err_mask(err_mask), .err_count(err_count)
  );

  gate_vector_sequencer #(.HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .gate_y(gate_y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_mask(err_mask1), .err_count(err_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full run on the H=4 instance; start is randomly toggled while busy.
  task automatic run_and_check(input string tag);
    logic [6:0] em;
    int ec, done_at, n_done, bad_ab, bad_busy, last;
    logic [1:0] exp_ab;
    em = 7'h00;
    ec = 0;
    for (int v = 0; v < 4; v++) begin
      em |= fault[v];
      if (fault[v] != 7'h00) ec++;
    end
    last = 4 * (H + 1) + 1;
    done_at = 0; n_done = 0; bad_ab = 0; bad_busy = 0;
    step();
    start = 1'b1;
    for (int n = 1; n <= last + 1; n++) begin
      step();
      start = (n <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_ab = (n < last) ? 2'((n - 1) / (H + 1)) : 2'b00;
      if ({a, b} !== exp_ab) bad_ab++;
      if (busy !== (n <= last)) bad_busy++;
      if (done === 1'b1) begin
        n_done++;
        if (done_at == 0) done_at = n;
      end
      if (n == last) begin
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, ec == 0});
        check({tag, "_err_mask"}, {25'd0, err_mask}, {25'd0, em});
        check({tag, "_err_count"}, {29'd0, err_count}, 32'(ec));
      end
    end
    check({tag, "_done_cycle"}, 32'(done_at), 32'(last));
    check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    check({tag, "_ab_seq"}, 32'(bad_ab), 32'd0);
    check({tag, "_busy"}, 32'(bad_busy), 32'd0);
  endtask

  task automatic set_faults(input int kind);
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      vv = v[1:0];
      case (kind)
        0: fault[v] = 7'h00;
        1: fault[v] = gold(vv[1], vv[0]) & 7'h20;
        2: fault[v] = 7'h7F;
        default: fault[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      endcase
    end
  endtask

  initial begin
    int done_at1, n_dones;
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    for (int v = 0; v < 4; v++) begin
      fault[v]  = 7'h00;
      fault1[v] = 7'h00;
    end
    repeat (3) step();
    check("rst_ab", {30'd0, a, b}, 32'd0);
    check("rst_flags", {29'd0, busy, done, pass}, 32'd0);
    check("rst_errs", {22'd0, err_mask, err_count}, 32'd0);
    rst = 1'b0;

    set_faults(0); run_and_check("good");
    set_faults(1); run_and_check("xy0");
    set_faults(2); run_and_check("inv");

    // Reset during vector 10 APPLY aborts the run without done.
    set_faults(0);
    fault[0] = 7'h01;
    step();
    start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      start = 1'b0;
      if (n == 11) check("pre_rst_mask", {25'd0, err_mask}, 32'h01);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ab", {30'd0, a, b}, 32'd0);
    check("midrst_flags", {29'd0, busy, done, pass}, 32'd0);
    check("midrst_errs", {22'd0, err_mask, err_count}, 32'd0);
    n_dones = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (done === 1'b1) n_dones++;
    end
    check("midrst_no_done", 32'(n_dones), 32'd0);
    run_and_check("after_rst");

    // start held high on the H=1 instance: back-to-back runs.
    fault1[1] = 7'h04;
    start1 = 1'b1;
    done_at1 = 0;
    for (int n = 1; n <= 11; n++) begin
      step();
      if (done1 === 1'b1 && done_at1 == 0) done_at1 = n;
      if (n == 9) begin
        check("h1_mask", {25'd0, err_mask1}, 32'h04);
        check("h1_count", {29'd0, err_count1}, 32'd1);
      end
      if (n == 10) check("h1_idle_busy", {31'd0, busy1}, 32'd0);
      if (n == 11) begin
        check("h1_restart_busy", {31'd0, busy1}, 32'd1);
        check("h1_restart_errs", {22'd0, err_mask1, err_count1}, 32'd0);
        check("h1_restart_ab", {30'd0, a1, b1}, 32'd0);
      end
    end
    check("h1_done_cycle", 32'(done_at1), 32'd9);
    start1 = 1'b0;

    for (int r = 0; r < 10; r++) begin
      set_faults(3);
      run_and_check($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
